// File: rtl/dice_roll_controller.sv
// Dice roller front end: debounces the board button, then drives a decelerating
// burst of roll pulses into the dice generator and captures the final face.
module dice_roll_controller #(
  parameter int DEBOUNCE_CYCLES = 1_250_000,
  parameter int TUMBLE_STEPS    = 8,
  parameter int STEP_BASE       = 3_125_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [2:0] dice_in,
  output logic       roll_out,
  output logic [2:0] show,
  output logic       busy,
  output logic [2:0] result,
  output logic       result_valid,
  output logic [1:0] state_dbg
);

  localparam int TW_RAW = $clog2(STEP_BASE * TUMBLE_STEPS);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam int SW_RAW = $clog2(TUMBLE_STEPS);
  localparam int SW     = (SW_RAW < 1) ? 1 : SW_RAW;
  localparam int CW_RAW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  // One spare bit so STEP_BASE*(step+1) is formed without overflow before the -1.
  localparam int PW     = TW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic            sync1;
  logic            sync2;
  logic            btn_db;
  logic            btn_db_q;
  logic [CW-1:0]   db_cnt;
  logic            press;
  logic [SW-1:0]   step;
  logic [TW-1:0]   timer;
  logic [PW-1:0]   wait_prod;

  // Button conditioning: 2-flop synchronizer, then a level change is accepted
  // only after DEBOUNCE_CYCLES consecutive samples that disagree with btn_db.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      btn_db_q <= btn_db;
      if (sync2 != btn_db) begin
        if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          btn_db <= ~btn_db;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press     = btn_db & ~btn_db_q;
  assign wait_prod = PW'(STEP_BASE) * (PW'(step) + PW'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      step   <= '0;
      timer  <= '0;
      show   <= 3'd0;
      result <= 3'd0;
    end else begin
      if (state != IDLE) begin
        show <= dice_in;
      end
      case (state)
        IDLE: begin
          if (press) begin
            step  <= '0;
            state <= PULSE;
          end
        end
        PULSE: begin
          timer <= TW'(wait_prod - PW'(1));
          state <= WAIT;
        end
        WAIT: begin
          if (timer == '0) begin
            if (step == SW'(TUMBLE_STEPS - 1)) begin
              result <= dice_in;
              state  <= DONE;
            end else begin
              step  <= step + SW'(1);
              state <= PULSE;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore outputs decoded straight from the state register.
  assign roll_out     = (state == PULSE);
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign state_dbg    = state;

endmodule

// File: tb/tb_dice_roll_controller.sv
// Bench for dice_roll_controller with small parameters (debounce 4, 3 steps, base 2).
module tb_dice_roll_controller;

  localparam int D = 4;
  localparam int N = 3;
  localparam int B = 2;
  // btn raised at a negedge with cyc=c gives the first roll_out sampled at cyc=c+7.
  localparam int PRESS_LAT = D + 3;
  localparam int DONE_REL  = 15;

  int pulse_rel [3] = '{0, 3, 8};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn = 1'b0;
  logic [2:0] dice_in = 3'd6;
  logic       roll_out;
  logic [2:0] show;
  logic       busy;
  logic [2:0] result;
  logic       result_valid;
  logic [1:0] state_dbg;

  dice_roll_controller #(
    .DEBOUNCE_CYCLES(D),
    .TUMBLE_STEPS   (N),
    .STEP_BASE      (B)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .dice_in     (dice_in),
    .roll_out    (roll_out),
    .show        (show),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dice generator model: face = base + pulse index, updated one cycle after each pulse
  logic [1:0] k_cnt = 2'd0;
  logic [2:0] face_base = 3'd1;
  always @(posedge clk) begin
    if (!busy) begin
      k_cnt <= 2'd0;
    end else if (roll_out) begin
      k_cnt   <= k_cnt + 2'd1;
      dice_in <= face_base + 3'(k_cnt);
    end
  end

  // scoreboard
  logic [31:0] roll_q[$];
  logic [31:0] rv_cyc_q[$];
  logic [2:0]  rv_res_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_seq(input int c, input logic [2:0] res, input int npulses, input bit done);
    for (int i = 0; i < npulses; i++) roll_q.push_back(32'(c + PRESS_LAT + pulse_rel[i]));
    if (done) begin
      rv_cyc_q.push_back(32'(c + PRESS_LAT + DONE_REL));
      rv_res_q.push_back(res);
    end
  endtask

  // driver tasks
  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] base, output int c);
    face_base = base;
    btn = 1'b1;
    c = cyc;
  endtask

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (roll_out === 1'b1) begin
        if (roll_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_roll: roll_out=1 at cycle %0d, required 0", cyc);
        end else begin
          check("roll_cycle", 32'(cyc), roll_q.pop_front());
        end
      end
      if (result_valid === 1'b1) begin
        if (rv_cyc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: result_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          logic [2:0] r;
          r = rv_res_q.pop_front();
          check("valid_cycle", 32'(cyc), rv_cyc_q.pop_front());
          check("result", 32'(result), 32'(r));
          check("show_at_done", 32'(show), 32'(r));
        end
      end
    end
  end

  // stimulus
  initial begin
    int c;
    rst = 1'b0;
    btn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_roll", 32'(roll_out), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_valid", 32'(result_valid), 0);
      check("rst_show", 32'(show), 0);
      check("rst_result", 32'(result), 0);
      check("rst_state", 32'(state_dbg), 0);
    end
    rst = 1'b1;
    btn = 1'b0;
    repeat (8) @(negedge clk);

    // clean press, faces 1,2,3
    press(3'd1, c);
    expect_seq(c, 3'd3, 3, 1'b1);
    wait_until(c + 6);  check("busy_before", 32'(busy), 0);
    wait_until(c + 7);  check("busy_first", 32'(busy), 1);
    wait_until(c + 22); check("busy_done", 32'(busy), 1);
    wait_until(c + 23); check("busy_after", 32'(busy), 0);
    check("result_hold", 32'(result), 3);
    check("show_hold", 32'(show), 3);
    btn = 1'b0;
    wait_until(c + 33);

    // bounce: highs of 1,2,3 cycles with 1-cycle lows, then a clean press
    for (int w = 1; w <= 3; w++) begin
      btn = 1'b1;
      repeat (w) @(negedge clk);
      btn = 1'b0;
      @(negedge clk);
    end
    check("bounce_idle", 32'(busy), 0);
    press(3'd2, c);
    expect_seq(c, 3'd4, 3, 1'b1);
    wait_until(c + 10);
    btn = 1'b0;
    wait_until(c + 30);

    // hold through DONE and beyond, then release and press again
    press(3'd3, c);
    expect_seq(c, 3'd5, 3, 1'b1);
    wait_until(c + 32);
    btn = 1'b0;
    wait_until(c + 42);
    press(3'd4, c);
    expect_seq(c, 3'd6, 3, 1'b1);
    wait_until(c + 10);
    btn = 1'b0;
    wait_until(c + 30);

    // second debounced press while busy is discarded
    press(3'd1, c);
    expect_seq(c, 3'd3, 3, 1'b1);
    wait_until(c + 4);
    btn = 1'b0;
    wait_until(c + 12);
    btn = 1'b1;
    wait_until(c + 18);
    btn = 1'b0;
    wait_until(c + 32);
    check("busy_press_idle", 32'(busy), 0);

    // reset mid-sequence at relative cycle 6
    press(3'd2, c);
    expect_seq(c, 3'd0, 2, 1'b0);
    wait_until(c + 4);
    btn = 1'b0;
    wait_until(c + 13);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_result", 32'(result), 0);
    check("abort_valid", 32'(result_valid), 0);
    check("abort_state", 32'(state_dbg), 0);
    check("abort_show", 32'(show), 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    press(3'd1, c);
    expect_seq(c, 3'd3, 3, 1'b1);
    wait_until(c + 10);
    btn = 1'b0;
    wait_until(c + 30);

    repeat (5) @(negedge clk);
    check("roll_q_empty", 32'(roll_q.size()), 0);
    check("rv_q_empty", 32'(rv_cyc_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dice_roll_controller.md
# dice_roll_controller

Front-end controller for the dice roller. Debounces the raw board button, then drives the dice generator's `roll` input with a decelerating "tumble" burst of single-cycle pulses. It mirrors each intermediate face to the display, and captures the final face with a one-cycle valid strobe. It sits between the push-button/LED pins and the dice generator, acting as the initiator of every roll request.

## Interface
- `DEBOUNCE_CYCLES`, default 1_250_000: consecutive stable samples required to accept a button level change (10 ms at 125 MHz).
- `TUMBLE_STEPS`, default 8: number of roll pulses per press (N); must be ≥1.
- `STEP_BASE`, default 3_125_000: base wait unit in cycles; wait after pulse k is `STEP_BASE*(k+1)`.

- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `btn`  in  1  raw, asynchronous, bouncy push-button (high = pressed).
- `dice_in`  in  3  current face from the dice generator, 1..6.
- `roll_out`  out  1  one-cycle roll request to the dice generator.
- `show`  out  3  face to display.
- `busy`  out  1  high while a roll sequence is in progress.
- `result`  out  3  final face of the last completed roll.
- `result_valid`  out  1  one-cycle strobe; `result` is valid in the same cycle.

## Operation
- **Input conditioning**
  - `btn` passes through a 2-flop synchronizer to give `btn_s`.
  - Debounce counter: while `btn_s` differs from `btn_db`, count up; after `DEBOUNCE_CYCLES` consecutive differing samples, toggle `btn_db` and clear the count.
  - Any matching sample clears the count, so glitches shorter than `DEBOUNCE_CYCLES` are dropped.
- **Press detect:** `press` = `btn_db & ~btn_db_q`, the rising edge of the debounced level.
- **FSM states:** IDLE, PULSE, WAIT, DONE. Step counter `step` runs 0..N-1; `timer` is a down-counter.
  - IDLE: `busy`=0. On `press`, set `step`=0 and go to PULSE.
  - PULSE: `roll_out`=1 for exactly this cycle. Load `timer`=`STEP_BASE*(step+1)-1` and go to WAIT.
  - WAIT: decrement `timer`. When `timer`==0:
    - if `step`==N-1, capture `result`<=`dice_in` and go to DONE;
    - otherwise increment `step` and go to PULSE.
  - DONE: `result_valid`=1 for this one cycle, then go to IDLE.
- **Outputs:**
  - `busy`=1 in PULSE, WAIT and DONE.
  - `roll_out` and `result_valid` are Moore outputs, decoded from the state register.
  - `show` <= `dice_in` every cycle the state is not IDLE; it holds in IDLE.
  - `result` changes only on the WAIT→DONE capture.
- **Widths:**
  - `timer` is `$clog2(STEP_BASE*N)` bits.
  - `step` is `$clog2(N)` bits, minimum 1.
  - Debounce counter is `$clog2(DEBOUNCE_CYCLES+1)` bits.
  - Wait products are computed at full width; no truncation is allowed.

## Timing
- **Reset values** (while `rst`=0 at a clock edge):
  - state IDLE; `roll_out`=0, `busy`=0, `result_valid`=0;
  - `show`=0 (blank), `result`=0;
  - synchronizer flops, `btn_db` and `btn_db_q` = 0; all counters 0.
- **Button to first pulse:** count the edge that first samples `btn`=1 as edge 0. Given a clean press, `btn_db` rises at edge `DEBOUNCE_CYCLES+1`, and `roll_out` is high in the cycle after edge `DEBOUNCE_CYCLES+2`.
- **Sequence length:** from the first `roll_out` cycle (cycle 0), `result_valid` is high at cycle `N + STEP_BASE*N*(N+1)/2`.
  - Pulse k occurs at cycle `k + STEP_BASE*k*(k+1)/2`.
- **Dice generator latency:** the generator updates `dice_in` one cycle after `roll_out`. Every WAIT lasts ≥1 cycle, so the captured `result` always reflects the last pulse.
- **Presses:**
  - Presses while `busy`=1, including in the DONE cycle, are discarded, not queued.
  - A button still held after DONE does not retrigger; a release and a new debounced press are required.
- **Reset mid-sequence:** the sequence aborts to IDLE the next cycle, with no `result_valid` and `result` cleared to 0.
  - The generator's own LFSR state is unaffected by this block.

## Test plan
Unless stated otherwise, benches use `DEBOUNCE_CYCLES`=4, `TUMBLE_STEPS`=3, `STEP_BASE`=2.

1. **Reset:** hold `rst`=0 for 3 cycles with `btn`=1 → `roll_out`, `busy`, `result_valid`, `show`, `result` all 0; no pulse during reset.
2. **Clean press, stepped generator:** `btn`=1 held, `dice_in` stepping 1→2→3 one cycle after each pulse → `roll_out` at relative cycles 0, 3, 8; `result_valid` only at cycle 15 with `result`=3; `busy` high cycles 0–15.
3. **Bounce:** `btn` toggles with high widths of 1, 2, 3 cycles separated by 1-cycle lows → no `roll_out`. A following 4+ cycle high → exactly one sequence starts.
4. **Hold and re-press:** hold `btn` through DONE and 10 more cycles → one sequence only. Release ≥4 cycles, then press again → second sequence, same cycle offsets as scenario 2.
5. **Press during busy:** a second debounced press at relative cycle 5 → ignored; exactly 3 `roll_out` pulses and one `result_valid` in total.
6. **Reset mid-sequence:** `rst`=0 at relative cycle 6 → next cycle IDLE, `busy`=0, `result`=0, no `result_valid`; a fresh press afterwards runs a full sequence.
